// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared state encoding, digit sizing and timer sizing helper for the code lock
package code_lock_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/code_lock_press_qualify.sv
// press_qualify: debounces the switch detector and emits one digit_valid pulse per press
module press_qualify
    import code_lock_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               good_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [DIGIT_W-1:0] digit_o
);

    localparam int            CW  = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DIGIT_W-1:0] prev_q;
    logic               armed_q, armed_d;

    // stability count saturates at DEB; a held switch stays disarmed until good drops
    always_comb begin
        cnt_d   = (good_i && digit_i == prev_q && !flush_i) ? ((cnt_q == DEB) ? cnt_q : cnt_q + 1'b1) : '0;
        valid_o = armed_q && cnt_q == DEB;
        armed_d = (valid_o || flush_i) ? 1'b0 : (!good_i ? 1'b1 : armed_q);
    end

    assign digit_o = prev_q;

    // qualifier state; reset leaves it disarmed so a switch held through reset is not taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            prev_q  <= digit_i;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/code_lock.sv
// code_lock: four-digit keypad lock with entry timeout, timed opening and lockout after repeated failures
module code_lock
    import code_lock_pkg::*;
#(
    parameter logic [CODE_W-1:0] CODE           = 16'h2507,
    parameter int                DEBOUNCE       = 4,
    parameter int                OPEN_CYCLES    = 100,
    parameter int                MAX_FAILS      = 3,
    parameter int                LOCKOUT_CYCLES = 200,
    parameter int                TIMEOUT        = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               good,
    input  logic [DIGIT_W-1:0] input_out,
    output logic               unlocked,
    output logic               error,
    output logic               lockout,
    output logic [CNT_W-1:0]   digits_entered
);

    localparam int               TMAX       = max3(OPEN_CYCLES, LOCKOUT_CYCLES, TIMEOUT);
    localparam int               TW         = $clog2(TMAX + 1);
    localparam int               FW         = $clog2(MAX_FAILS + 1);
    localparam logic [TW-1:0]    TSAT       = TW'(TMAX);
    localparam logic [TW-1:0]    OPEN_LAST  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0]    LOCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0]    ENTRY_LAST = TW'(TIMEOUT - 1);
    localparam logic [FW-1:0]    FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ALL_DIGITS = CNT_W'(NUM_DIGITS);

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [FW-1:0]      fails_q, fails_d, fails_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_q, code_d, code_base;
    logic               press_valid;
    logic [DIGIT_W-1:0] press_digit;
    logic               take, match, fail_limit, flush;

    press_qualify #(
        .DEBOUNCE(DEBOUNCE)
    ) u_press (
        .clk    (clk),
        .rst_n  (rst_n),
        .good_i (good),
        .digit_i(input_out),
        .flush_i(flush),
        .valid_o(press_valid),
        .digit_o(press_digit)
    );

    assign take       = press_valid && (state_q == S_IDLE || state_q == S_ENTRY);
    assign match      = code_q == CODE;
    assign fails_inc  = (fails_q == FAIL_MAX) ? fails_q : fails_q + 1'b1;
    assign fail_limit = fails_inc >= FAIL_MAX;
    assign flush      = state_d != state_q && (state_d == S_OPEN || state_d == S_LOCKOUT);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = take ? S_ENTRY : S_IDLE;
            S_ENTRY:   state_d = (take && cnt_q == LAST_DIGIT) ? S_CHECK :
                                 ((!take && timer_q == ENTRY_LAST) ? S_IDLE : S_ENTRY);
            S_CHECK:   state_d = match ? S_OPEN : (fail_limit ? S_LOCKOUT : S_IDLE);
            S_OPEN:    state_d = (timer_q == OPEN_LAST) ? S_IDLE : S_OPEN;
            S_LOCKOUT: state_d = (timer_q == LOCK_LAST) ? S_IDLE : S_LOCKOUT;
            default:   state_d = S_IDLE;
        endcase
    end

    // timer restarts on every state change and every taken digit; digit count and fail count follow the state
    always_comb begin
        timer_d   = (state_d != state_q || take) ? '0 : ((timer_q == TSAT) ? timer_q : timer_q + 1'b1);
        cnt_d     = (state_d == S_ENTRY) ? (take ? cnt_q + 1'b1 : cnt_q) : '0;
        code_base = (state_q == S_IDLE) ? '0 : code_q;
        code_d    = take ? {code_base[CODE_W-DIGIT_W-1:0], press_digit} : code_q;
        fails_d   = (state_q == S_CHECK) ? (match ? '0 : fails_inc) :
                    ((state_q == S_LOCKOUT && state_d == S_IDLE) ? '0 : fails_q);
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            fails_q <= '0;
        end else begin
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            fails_q <= fails_d;
        end
    end

    // outputs decoded from the current state
    always_comb begin
        unlocked       = state_q == S_OPEN;
        lockout        = state_q == S_LOCKOUT;
        error          = state_q == S_CHECK && !match;
        digits_entered = (state_q == S_CHECK) ? ALL_DIGITS : ((state_q == S_ENTRY) ? cnt_q : '0);
    end

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: randomized scoreboard bench for the code lock
module tb_code_lock;

    localparam logic [15:0] GOOD_CODE = 16'h2507;
    localparam int          OPEN_LEN  = 100;
    localparam int          LOCK_LEN  = 200;
    localparam int          FAIL_LIM  = 3;

    typedef enum {EV_ERR, EV_OPEN, EV_LOCK} ev_t;
    typedef struct {
        ev_t kind;
        int  len;
    } ev_s;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       good = 1'b0;
    logic [3:0] input_out = '0;
    logic       unlocked, error, lockout;
    logic [2:0] digits_entered;

    int          checks = 0;
    int          errors = 0;
    ev_s         exp_q[$];
    int          fails_m = 0;
    int          ndig = 0;
    int          outcome = 0;
    logic [15:0] mcode = '0;

    code_lock dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .good          (good),
        .input_out     (input_out),
        .unlocked      (unlocked),
        .error         (error),
        .lockout       (lockout),
        .digits_entered(digits_entered)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input int hold, input int gap);
        input_out = d;
        good = 1'b1;
        cycles(hold);
        good = 1'b0;
        input_out = '0;
        cycles(gap);
    endtask

    // reference outcome of a complete four-digit attempt
    task automatic judge(input logic [15:0] c);
        if (c == GOOD_CODE) begin
            exp_q.push_back(ev_s'{EV_OPEN, OPEN_LEN});
            fails_m = 0;
            outcome = 1;
        end else begin
            exp_q.push_back(ev_s'{EV_ERR, 1});
            fails_m++;
            outcome = 0;
            if (fails_m == FAIL_LIM) begin
                exp_q.push_back(ev_s'{EV_LOCK, LOCK_LEN});
                fails_m = 0;
                outcome = 2;
            end
        end
    endtask

    task automatic enter(input logic [3:0] d, input int hold, input int gap);
        mcode = {mcode[11:0], d};
        ndig++;
        if (ndig == 4) begin
            judge(mcode);
            ndig = 0;
        end
        press(d, hold, gap);
        check("digits_entered", int'(digits_entered), ndig);
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) enter(c[15-4*i -: 4], $urandom_range(6, 10), $urandom_range(1, 4));
    endtask

    task automatic settle();
        cycles(outcome == 1 ? OPEN_LEN + 15 : (outcome == 2 ? LOCK_LEN + 15 : 3));
        outcome = 0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        fails_m = 0;
        ndig = 0;
        outcome = 0;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_unlocked"}, int'(unlocked), 0);
        check({tag, "_error"}, int'(error), 0);
        check({tag, "_lockout"}, int'(lockout), 0);
        check({tag, "_digits"}, int'(digits_entered), 0);
    endtask

    task automatic expect_ev(input ev_t k, input int len);
        ev_s e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got pulse of %0d cycles, expected none", k.name(), len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.len != len) begin
                errors++;
                $display("FAIL event: got %s for %0d cycles, expected %s for %0d cycles",
                         k.name(), len, e.kind.name(), e.len);
            end
        end
    endtask

    // monitor: measures each output pulse and retires it against the scoreboard when it ends
    initial begin : monitor
        int run_e, run_u, run_l;
        run_e = 0;
        run_u = 0;
        run_l = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_e = 0;
                run_u = 0;
                run_l = 0;
            end else begin
                if (error) run_e++;
                else if (run_e > 0) begin
                    expect_ev(EV_ERR, run_e);
                    run_e = 0;
                end
                if (unlocked) run_u++;
                else if (run_u > 0) begin
                    expect_ev(EV_OPEN, run_u);
                    run_u = 0;
                end
                if (lockout) run_l++;
                else if (run_l > 0) begin
                    expect_ev(EV_LOCK, run_l);
                    run_l = 0;
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] c;
        #2 rst_n = 1'b0;
        #1 check_all_low("reset");
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // correct code with 6-cycle holds and 2-cycle gaps
        for (int i = 0; i < 4; i++) enter(GOOD_CODE[15-4*i -: 4], 6, 2);
        settle();

        // short hold and a toggling digit are never accepted
        press(4'd3, 3, 2);
        check("short_hold", int'(digits_entered), 0);
        good = 1'b1;
        for (int i = 0; i < 10; i++) begin
            input_out = (i % 2 == 0) ? 4'd1 : 4'd6;
            cycles(2);
        end
        good = 1'b0;
        cycles(2);
        check("toggle", int'(digits_entered), 0);

        // long hold gives one digit, then the code completes and opens
        enter(4'd2, 50, 2);
        enter(4'd5, 6, 2);
        enter(4'd0, 7, 3);
        enter(4'd7, 8, 1);
        settle();

        // entry timeout aborts silently, then a correct code still opens
        enter(4'd2, 6, 2);
        enter(4'd5, 6, 2);
        cycles(1005);
        ndig = 0;
        check("timeout_digits", int'(digits_entered), 0);
        enter_code(GOOD_CODE);
        settle();

        // three wrong codes trigger lockout; a press during lockout is ignored
        enter_code(16'h2506);
        settle();
        enter_code(16'h2506);
        settle();
        enter_code(16'h2506);
        press(4'd2, 8, 2);
        check("lockout_press_digits", int'(digits_entered), 0);
        check("lockout_active", int'(lockout), 1);
        cycles(LOCK_LEN);
        outcome = 0;

        // randomized attempts
        for (int a = 0; a < 8; a++) begin
            if ($urandom_range(0, 2) == 0) c = GOOD_CODE;
            else for (int i = 0; i < 4; i++) c[15-4*i -: 4] = 4'($urandom_range(0, 7));
            enter_code(c);
            settle();
        end

        // reset during OPEN clears outputs at once
        enter_code(GOOD_CODE);
        cycles(30);
        rst_n = 1'b0;
        #1 check_all_low("rst_open");
        model_reset();
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        // reset during the third digit; the switch held across release is not taken
        enter(4'd2, 6, 2);
        enter(4'd5, 6, 2);
        input_out = 4'd0;
        good = 1'b1;
        cycles(3);
        rst_n = 1'b0;
        #1 check_all_low("rst_entry");
        model_reset();
        cycles(2);
        rst_n = 1'b1;
        cycles(10);
        check("held_through_reset", int'(digits_entered), 0);
        good = 1'b0;
        cycles(2);

        // two wrong codes then the correct code opens without lockout
        enter_code(16'h2506);
        settle();
        enter_code(16'h1111);
        settle();
        enter_code(GOOD_CODE);
        check("no_lockout", int'(lockout), 0);
        settle();

        for (int i = 0; i < 400 && exp_q.size() > 0; i++) cycles(1);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
